// File: rtl/adc_align_ctrl.sv
// ADC data-eye alignment controller: sweeps IDELAY taps to find the widest
// passing eye, centres on it, then bitslips the ISERDES until word framing matches.
module adc_align_ctrl #(
   parameter int unsigned P_N_TAPS  = 32,
   parameter int unsigned P_SETTLE  = 16,
   parameter int unsigned P_N_CHECK = 64,
   parameter int unsigned P_MIN_EYE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [11:0] pattern_i,
   input  logic [11:0] adc_samp_0_i,
   input  logic [11:0] adc_samp_1_i,
   output logic [4:0]  idelay_tap_o,
   output logic        idelay_ld_o,
   output logic        bitslip_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        fail_o,
   output logic [4:0]  eye_start_o,
   output logic [5:0]  eye_width_o,
   output logic [3:0]  n_slip_o
);

   localparam int unsigned SW = $clog2(P_SETTLE + 1);
   localparam int unsigned CW = $clog2(P_N_CHECK + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(P_SETTLE - 1);
   localparam logic [CW-1:0] CHECK_LAST  = CW'(P_N_CHECK - 1);
   localparam logic [4:0]    LAST_TAP    = 5'(P_N_TAPS - 1);
   localparam logic [5:0]    MIN_EYE     = 6'(P_MIN_EYE);
   localparam logic [3:0]    MAX_SLIP    = 4'd11;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_CHECK,
      S_NEXT_TAP,
      S_CENTER,
      S_SLIP_CHECK,
      S_SLIP,
      S_DONE,
      S_FAIL
   } state_e;

   // True when samp equals pat rotated left by any of the 12 word positions.
   function automatic logic rot_match(input logic [11:0] samp, input logic [11:0] pat);
      logic hit;
      logic [11:0] rot;
      hit = 1'b0;
      for (int r = 0; r < 12; r++) begin
         rot = (pat << r) | (pat >> (12 - r));
         hit = hit | (samp == rot);
      end
      return hit;
   endfunction

   state_e          state_q, state_d;
   logic [4:0]      tap_q, tap_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic [CW-1:0]   check_q, check_d;
   logic            slip_phase_q, slip_phase_d;
   logic            pass_q, pass_d;
   logic [4:0]      run_start_q, run_start_d;
   logic [5:0]      run_len_q, run_len_d;
   logic [4:0]      best_start_q, best_start_d;
   logic [5:0]      best_len_q, best_len_d;
   logic [4:0]      eye_start_q, eye_start_d;
   logic [5:0]      eye_width_q, eye_width_d;
   logic [3:0]      n_slip_q, n_slip_d;
   logic            ld_q, ld_d;
   logic            bs_q, bs_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            fail_q, fail_d;

   logic            sweep_ok_s;
   logic            exact_ok_s;
   logic [5:0]      run_len_inc_s;
   logic [5:0]      cur_len_s;
   logic [4:0]      cur_start_s;
   logic            close_s;
   logic            take_s;
   logic [5:0]      new_best_len_s;
   logic [4:0]      new_best_start_s;

   assign sweep_ok_s = rot_match(adc_samp_0_i, pattern_i) & rot_match(adc_samp_1_i, pattern_i);
   assign exact_ok_s = (adc_samp_0_i == pattern_i) & (adc_samp_1_i == pattern_i);

   // A run still open at the last tap is closed there so an eye touching tap 31 counts.
   assign run_len_inc_s    = run_len_q + 6'd1;
   assign cur_len_s        = pass_q ? run_len_inc_s : run_len_q;
   assign cur_start_s      = (pass_q && (run_len_q == 6'd0)) ? tap_q : run_start_q;
   assign close_s          = (!pass_q) || (tap_q == LAST_TAP);
   assign take_s           = close_s && (cur_len_s > best_len_q);
   assign new_best_len_s   = take_s ? cur_len_s : best_len_q;
   assign new_best_start_s = take_s ? cur_start_s : best_start_q;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d      = state_q;
      tap_d        = tap_q;
      settle_d     = settle_q;
      check_d      = check_q;
      slip_phase_d = slip_phase_q;
      pass_d       = pass_q;
      run_start_d  = run_start_q;
      run_len_d    = run_len_q;
      best_start_d = best_start_q;
      best_len_d   = best_len_q;
      eye_start_d  = eye_start_q;
      eye_width_d  = eye_width_q;
      n_slip_d     = n_slip_q;

      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start_i) begin
               state_d      = S_LOAD;
               tap_d        = 5'd0;
               settle_d     = '0;
               check_d      = '0;
               slip_phase_d = 1'b0;
               pass_d       = 1'b0;
               run_start_d  = 5'd0;
               run_len_d    = 6'd0;
               best_start_d = 5'd0;
               best_len_d   = 6'd0;
               eye_start_d  = 5'd0;
               eye_width_d  = 6'd0;
               n_slip_d     = 4'd0;
            end else begin
               state_d = state_q;
            end
         end
         S_LOAD: begin
            settle_d = '0;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               check_d = '0;
               state_d = slip_phase_q ? S_SLIP_CHECK : S_CHECK;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         S_CHECK: begin
            if (!sweep_ok_s) begin
               pass_d  = 1'b0;
               state_d = S_NEXT_TAP;
            end else if (check_q == CHECK_LAST) begin
               pass_d  = 1'b1;
               state_d = S_NEXT_TAP;
            end else begin
               check_d = check_q + CW'(1);
            end
         end
         S_NEXT_TAP: begin
            run_start_d  = cur_start_s;
            run_len_d    = pass_q ? run_len_inc_s : 6'd0;
            best_start_d = new_best_start_s;
            best_len_d   = new_best_len_s;
            if (tap_q == LAST_TAP) begin
               if (new_best_len_s < MIN_EYE) begin
                  state_d = S_FAIL;
               end else begin
                  eye_start_d = new_best_start_s;
                  eye_width_d = new_best_len_s;
                  state_d     = S_CENTER;
               end
            end else begin
               tap_d   = tap_q + 5'd1;
               state_d = S_LOAD;
            end
         end
         S_CENTER: begin
            // The run lies wholly inside 0..31, so the midpoint cannot overflow 5 bits.
            tap_d        = eye_start_q + eye_width_q[5:1];
            slip_phase_d = 1'b1;
            state_d      = S_LOAD;
         end
         S_SLIP_CHECK: begin
            if (!exact_ok_s) begin
               state_d = S_SLIP;
            end else if (check_q == CHECK_LAST) begin
               state_d = S_DONE;
            end else begin
               check_d = check_q + CW'(1);
            end
         end
         S_SLIP: begin
            if (n_slip_q < MAX_SLIP) begin
               n_slip_d = n_slip_q + 4'd1;
               settle_d = '0;
               state_d  = S_SETTLE;
            end else begin
               state_d = S_FAIL;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ld_d   = (state_d == S_LOAD);
      bs_d   = (state_d == S_SLIP) && (n_slip_q < MAX_SLIP);
      done_d = (state_d == S_DONE);
      fail_d = (state_d == S_FAIL);
      busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_FAIL));
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         tap_q        <= 5'd0;
         settle_q     <= '0;
         check_q      <= '0;
         slip_phase_q <= 1'b0;
         pass_q       <= 1'b0;
         run_start_q  <= 5'd0;
         run_len_q    <= 6'd0;
         best_start_q <= 5'd0;
         best_len_q   <= 6'd0;
         eye_start_q  <= 5'd0;
         eye_width_q  <= 6'd0;
         n_slip_q     <= 4'd0;
         ld_q         <= 1'b0;
         bs_q         <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tap_q        <= tap_d;
         settle_q     <= settle_d;
         check_q      <= check_d;
         slip_phase_q <= slip_phase_d;
         pass_q       <= pass_d;
         run_start_q  <= run_start_d;
         run_len_q    <= run_len_d;
         best_start_q <= best_start_d;
         best_len_q   <= best_len_d;
         eye_start_q  <= eye_start_d;
         eye_width_q  <= eye_width_d;
         n_slip_q     <= n_slip_d;
         ld_q         <= ld_d;
         bs_q         <= bs_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
      end
   end

   assign idelay_tap_o = tap_q;
   assign idelay_ld_o  = ld_q;
   assign bitslip_o    = bs_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign fail_o       = fail_q;
   assign eye_start_o  = eye_start_q;
   assign eye_width_o  = eye_width_q;
   assign n_slip_o     = n_slip_q;

endmodule

// File: doc/adc_align_ctrl.md
ADC_ALIGN_CTRL -- requirements
Module: adc_align_ctrl

Interface
REQ-001 P_N_TAPS, 32, IDELAY taps swept (0..31).
REQ-002 P_SETTLE, 16, wait cycles after each tap load or bitslip.
REQ-003 P_N_CHECK, 64, consecutive clk cycles compared per check window.
REQ-004 P_MIN_EYE, 4, minimum passing-tap run accepted.
REQ-005 clk  in  1  lclk domain; one clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  single-cycle pulse; begins alignment.
REQ-008 pattern  in  12  expected ADC test pattern; held static while busy.
REQ-009 adc_samp_0, adc_samp_1  in  12 each  deserialized sample pair per clk.
REQ-010 idelay_tap  out  5  tap value to IDELAYE2 CNTVALUEIN.
REQ-011 idelay_ld  out  1  one-cycle load strobe.
REQ-012 bitslip  out  1  one-cycle ISERDES bitslip pulse.
REQ-013 busy, done, fail  out  1 each  status.
REQ-014 eye_start  out  5; eye_width  out  6; n_slip  out  4  result registers.

Function
REQ-015 States: IDLE, LOAD, SETTLE, CHECK, NEXT_TAP, CENTER, SLIP_CHECK, SLIP, DONE, FAIL.
REQ-016 IDLE/DONE/FAIL + start -> LOAD with tap=0; clears done, fail, eye_start, eye_width, n_slip, run trackers; start ignored while busy.
REQ-017 busy SHALL be 1 in every state except IDLE, DONE, FAIL.
REQ-018 LOAD: idelay_tap driven, idelay_ld=1 for exactly one cycle -> SETTLE.
REQ-019 SETTLE: count P_SETTLE cycles, ignore samples -> CHECK (sweep) or SLIP_CHECK (slip phase).
REQ-020 Sweep CHECK: sample pair "rotation-matches" if each of adc_samp_0, adc_samp_1 equals pattern rotated left by any of 0..11 bits; tap passes only if all P_N_CHECK cycles match; first mismatch may end window early.
REQ-021 NEXT_TAP run tracking: pass extends current run (start recorded at first pass); fail closes run; closed run replaces best only if strictly longer (ties keep lower start); run open at tap 31 closes after tap 31.
REQ-022 After tap 31: best_len < P_MIN_EYE -> FAIL; else eye_start=best_start, eye_width=best_len, -> CENTER.
REQ-023 CENTER: tap = eye_start + floor(eye_width/2), 5-bit result, never wraps -> LOAD -> SETTLE -> SLIP_CHECK.
REQ-024 SLIP_CHECK: exact match (both samples == pattern) for all P_N_CHECK cycles -> DONE; any mismatch -> SLIP.
REQ-025 SLIP: n_slip<11 -> bitslip=1 one cycle, n_slip+1, -> SETTLE; n_slip==11 -> FAIL (no bitslip pulse).
REQ-026 DONE/FAIL: sticky until next start or reset; idelay_tap holds last loaded value; eye/n_slip hold.
REQ-027 idelay_ld and bitslip never asserted simultaneously nor in consecutive cycles.

Reset
REQ-028 rst_n low, any state: immediately -> IDLE; busy, done, fail, idelay_ld, bitslip = 0; idelay_tap, eye_start, eye_width, n_slip = 0; counters cleared.
REQ-029 Release mid-operation: stays IDLE until start; no strobes emitted from reset.

Verification
REQ-030 Model eye taps 10..19, data pre-rotated 3 bits, pattern 12'hA5C: start -> eye_start=10, eye_width=10, final tap 15, 9 bitslip pulses (rotation closes at 12), n_slip=9, done=1.
REQ-031 Two eyes 2..5 and 20..25: eye_start=20, eye_width=6, tap 23; equal runs 2..5 and 20..23 -> eye_start=2.
REQ-032 Eye 28..31 (open at sweep end): eye_start=28, eye_width=4, tap 30, done=1; eye 29..31 -> fail=1, bitslip never pulsed.
REQ-033 Data never matches any rotation after centering (corrupt 1 bit): exactly 11 bitslip pulses then fail=1, n_slip=11.
REQ-034 rst_n low during SETTLE of tap 7: all outputs 0 same cycle; start after release restarts at tap 0, full 32-tap sweep.
REQ-035 start pulsed while busy: no effect on sequence; idelay_ld count per run = 33 (32 sweep + 1 center).
